// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, beat geometry and FSM state codes for the memory stage
package mem_pkg;

  localparam int ADDR_W     = 32;
  localparam int BEAT_W     = 32;
  localparam int VEC_W      = 128;
  localparam int BEATS      = VEC_W / BEAT_W;
  localparam int BEAT_BYTES = 4;

  // Serializer FSM state codes
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

endpackage

// File: rtl/memory_cycle_vec_if.sv
// rtl/memory_cycle_vec_if.sv - 32-bit data-memory beat port with req/ack handshake
interface memory_cycle_vec_if;
  import mem_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BEAT_W-1:0] mem_wdata;
  logic [BEAT_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/beat_serializer.sv
// rtl/beat_serializer.sv - splits scalar/vector accesses into 32-bit beats and assembles load data
module beat_serializer
  import mem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               memop,
  input  logic               is_vec,
  input  logic               we,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [VEC_W-1:0]   wdata,
  memory_cycle_vec_if.master mem,
  output logic               stall,
  output logic [VEC_W-1:0]   rdata_vec
);

  logic [0:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [VEC_W-1:0]  buf_q, buf_d;
  logic [1:0]        beat;
  logic [1:0]        last_idx;
  logic              last_beat;
  logic [ADDR_W-1:0] aligned;

  // Beat 0 is always issued from IDLE; later beats come from the counter
  assign beat      = (state_q == S_IDLE) ? 2'd0 : cnt_q;
  assign last_idx  = is_vec ? 2'(BEATS - 1) : 2'd0;
  assign last_beat = (beat == last_idx);
  assign aligned   = {base_addr[ADDR_W-1:2], 2'b00};

  // Bus drive, stall and load-data assembly with the final beat bypassed from the port
  always_comb begin
    mem.mem_req   = memop & ~rst;
    mem.mem_we    = we;
    mem.mem_addr  = aligned + ADDR_W'(beat) * ADDR_W'(BEAT_BYTES);
    mem.mem_wdata = wdata[{beat, 5'b0} +: BEAT_W];
    stall         = memop & ~rst & ~(mem.mem_ack & last_beat);
    rdata_vec     = buf_q;
    if (memop && mem.mem_ack && !we) begin
      rdata_vec[{beat, 5'b0} +: BEAT_W] = mem.mem_rdata;
    end
  end

  // FSM and beat counter advance on each ack; buffer is cleared when an op completes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    if (memop && mem.mem_ack) begin
      if (last_beat) begin
        state_d = S_IDLE;
        cnt_d   = 2'd0;
        buf_d   = '0;
      end else begin
        state_d = S_BURST;
        cnt_d   = beat + 2'd1;
        if (!we) begin
          buf_d[{beat, 5'b0} +: BEAT_W] = mem.mem_rdata;
        end
      end
    end
  end

  // State registers; reset aborts any burst in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: rtl/memory_cycle_vec.sv
// rtl/memory_cycle_vec.sv - memory pipeline stage: beat serializer, W register and ResultW mux
module memory_cycle_vec
  import mem_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               RegWriteM,
  input  logic               MemWriteM,
  input  logic               ResultSrcM,
  input  logic               is_vectorialM,
  input  logic [5:0]         RD_M,
  input  logic [31:0]        PCPlus4M,
  input  logic [VEC_W-1:0]   ALU_ResultM,
  input  logic [VEC_W-1:0]   WriteDataM,
  memory_cycle_vec_if.master mem,
  output logic               StallM,
  output logic               RegWriteW,
  output logic               ResultSrcW,
  output logic [5:0]         RD_W,
  output logic [31:0]        PCPlus4W,
  output logic [VEC_W-1:0]   ALU_ResultW,
  output logic [VEC_W-1:0]   ReadDataW,
  output logic [VEC_W-1:0]   ResultW
);

  logic             memop;
  logic             stall;
  logic [VEC_W-1:0] rdata_vec;

  logic             reg_write_w_q, reg_write_w_d;
  logic             result_src_w_q, result_src_w_d;
  logic [5:0]       rd_w_q, rd_w_d;
  logic [31:0]      pc_plus4_w_q, pc_plus4_w_d;
  logic [VEC_W-1:0] alu_result_w_q, alu_result_w_d;
  logic [VEC_W-1:0] read_data_w_q, read_data_w_d;

  assign memop = MemWriteM | ResultSrcM;

  beat_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .memop     (memop),
    .is_vec    (is_vectorialM),
    .we        (MemWriteM),
    .base_addr (ALU_ResultM[ADDR_W-1:0]),
    .wdata     (WriteDataM),
    .mem       (mem),
    .stall     (stall),
    .rdata_vec (rdata_vec)
  );

  // W capture when not stalled, else a bubble with the data fields held; store wins over load
  always_comb begin
    reg_write_w_d  = 1'b0;
    result_src_w_d = 1'b0;
    rd_w_d         = rd_w_q;
    pc_plus4_w_d   = pc_plus4_w_q;
    alu_result_w_d = alu_result_w_q;
    read_data_w_d  = read_data_w_q;
    if (!stall) begin
      reg_write_w_d  = RegWriteM & ~(MemWriteM & ResultSrcM);
      result_src_w_d = ResultSrcM & ~MemWriteM;
      rd_w_d         = RD_M;
      pc_plus4_w_d   = PCPlus4M;
      alu_result_w_d = ALU_ResultM;
      read_data_w_d  = rdata_vec;
    end
  end

  // W pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_w_q  <= 1'b0;
      result_src_w_q <= 1'b0;
      rd_w_q         <= '0;
      pc_plus4_w_q   <= '0;
      alu_result_w_q <= '0;
      read_data_w_q  <= '0;
    end else begin
      reg_write_w_q  <= reg_write_w_d;
      result_src_w_q <= result_src_w_d;
      rd_w_q         <= rd_w_d;
      pc_plus4_w_q   <= pc_plus4_w_d;
      alu_result_w_q <= alu_result_w_d;
      read_data_w_q  <= read_data_w_d;
    end
  end

  assign StallM      = stall;
  assign RegWriteW   = reg_write_w_q;
  assign ResultSrcW  = result_src_w_q;
  assign RD_W        = rd_w_q;
  assign PCPlus4W    = pc_plus4_w_q;
  assign ALU_ResultW = alu_result_w_q;
  assign ReadDataW   = read_data_w_q;
  assign ResultW     = result_src_w_q ? read_data_w_q : alu_result_w_q;

endmodule

// File: tb/tb_memory_cycle_vec.sv
// tb/tb_memory_cycle_vec.sv - directed self-checking bench for memory_cycle_vec
module tb_memory_cycle_vec;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         RegWriteM = 1'b0, MemWriteM = 1'b0, ResultSrcM = 1'b0, is_vectorialM = 1'b0;
  logic [5:0]   RD_M = '0;
  logic [31:0]  PCPlus4M = '0;
  logic [127:0] ALU_ResultM = '0, WriteDataM = '0;
  logic         StallM, RegWriteW, ResultSrcW;
  logic [5:0]   RD_W;
  logic [31:0]  PCPlus4W;
  logic [127:0] ALU_ResultW, ReadDataW, ResultW;

  memory_cycle_vec_if mem_bus();

  memory_cycle_vec dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .is_vectorialM(is_vectorialM), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
    .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
    .mem(mem_bus),
    .StallM(StallM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
    .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .ResultW(ResultW)
  );

  // Memory responder: ack after 'lat' waiting cycles; rdata = 0xA0 + word index within 16 bytes
  int          lat = 0;
  int          wait_cnt;
  logic        rd_fixed_en = 1'b0;
  logic [31:0] rd_fixed = '0;

  assign mem_bus.mem_ack   = mem_bus.mem_req && (wait_cnt == lat);
  assign mem_bus.mem_rdata = rd_fixed_en ? rd_fixed : (32'hA0 + {30'd0, mem_bus.mem_addr[3:2]});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (mem_bus.mem_req && mem_bus.mem_ack) wait_cnt <= 0;
    else if (mem_bus.mem_req) wait_cnt <= wait_cnt + 1;
  end

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic        log_we[$];

  always @(negedge clk) begin
    if (mem_bus.mem_req && mem_bus.mem_ack) begin
      log_addr.push_back(mem_bus.mem_addr);
      log_data.push_back(mem_bus.mem_wdata);
      log_we.push_back(mem_bus.mem_we);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_nop();
    RegWriteM = 1'b0; MemWriteM = 1'b0; ResultSrcM = 1'b0; is_vectorialM = 1'b0;
    RD_M = '0; PCPlus4M = '0; ALU_ResultM = '0; WriteDataM = '0;
  endtask

  // Drives one M-stage op (called #1 after a posedge) and returns #1 after the edge that captured it
  task automatic run_op(input logic rw, input logic mw, input logic rs, input logic vec,
                        input logic [5:0] rd, input logic [31:0] pc, input logic [127:0] alu,
                        input logic [127:0] wd, input int l,
                        output int stalls, output logic bubble_bad);
    logic st;
    int   n;
    stalls = 0; n = 0; bubble_bad = 1'b0;
    log_addr.delete(); log_data.delete(); log_we.delete();
    lat = l;
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; is_vectorialM = vec;
    RD_M = rd; PCPlus4M = pc; ALU_ResultM = alu; WriteDataM = wd;
    do begin
      @(negedge clk);
      st = StallM;
      if (st) stalls++;
      if (n >= 1 && (RegWriteW !== 1'b0 || ResultSrcW !== 1'b0)) bubble_bad = 1'b1;
      @(posedge clk); #1;
      n++;
    end while (st && n < 200);
    if (st) check_val("op_timeout", 128'(n), 128'd0);
    set_nop();
  endtask

  int   stalls;
  logic bbad;
  logic [31:0] exp_addr[4];
  logic [31:0] exp_data[4];

  initial begin
    // Reset with a memop presented: request and stall must stay low
    MemWriteM = 1'b1;
    #1;
    check_val("rst_req", 128'(mem_bus.mem_req), 128'd0);
    check_val("rst_stall", 128'(StallM), 128'd0);
    check_val("rst_resultw", ResultW, 128'd0);
    check_val("rst_regwritew", 128'(RegWriteW), 128'd0);
    set_nop();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: non-memory op passes through in one cycle
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 6'd5, 32'h1004, 128'h42, 128'h0, 0, stalls, bbad);
    check_val("t1_stalls", 128'(stalls), 128'd0);
    check_val("t1_regwritew", 128'(RegWriteW), 128'd1);
    check_val("t1_rdw", 128'(RD_W), 128'd5);
    check_val("t1_pcw", 128'(PCPlus4W), 128'h1004);
    check_val("t1_resultw", ResultW, 128'h42);

    // 3: vector load, ack 2 cycles after each request
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 6'd9, 32'h2008, 128'h300, 128'h0, 2, stalls, bbad);
    check_val("t3_stalls", 128'(stalls), 128'd11);
    check_val("t3_bubbles", 128'(bbad), 128'd0);
    check_val("t3_readdataw", ReadDataW, 128'h000000A3_000000A2_000000A1_000000A0);
    check_val("t3_resultw", ResultW, 128'h000000A3_000000A2_000000A1_000000A0);
    check_val("t3_regwritew", 128'(RegWriteW), 128'd1);
    check_val("t3_resultsrcw", 128'(ResultSrcW), 128'd1);
    check_val("t3_rdw", 128'(RD_W), 128'd9);

    // 2: vector store, ack every cycle
    run_op(1'b0, 1'b1, 1'b0, 1'b1, 6'd0, 32'h3000, 128'h100,
           128'h44444444_33333333_22222222_11111111, 0, stalls, bbad);
    check_val("t2_stalls", 128'(stalls), 128'd3);
    check_val("t2_nbeats", 128'(log_addr.size()), 128'd4);
    exp_addr = '{32'h100, 32'h104, 32'h108, 32'h10C};
    exp_data = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
      check_val($sformatf("t2_addr%0d", i), 128'(log_addr[i]), 128'(exp_addr[i]));
      check_val($sformatf("t2_data%0d", i), 128'(log_data[i]), 128'(exp_data[i]));
      check_val($sformatf("t2_we%0d", i), 128'(log_we[i]), 128'd1);
    end
    check_val("t2_regwritew", 128'(RegWriteW), 128'd0);
    check_val("t2_aluw", ALU_ResultW, 128'h100);

    // 4: scalar misaligned load, immediate ack; upper result bits must be zero
    rd_fixed_en = 1'b1; rd_fixed = 32'hDEADBEEF;
    run_op(1'b1, 1'b0, 1'b1, 1'b0, 6'd3, 32'h4000, 128'h203, 128'h0, 0, stalls, bbad);
    rd_fixed_en = 1'b0;
    check_val("t4_stalls", 128'(stalls), 128'd0);
    check_val("t4_nbeats", 128'(log_addr.size()), 128'd1);
    if (log_addr.size() > 0) check_val("t4_addr", 128'(log_addr[0]), 128'h200);
    check_val("t4_readdataw", ReadDataW, 128'hDEADBEEF);
    check_val("t4_resultw", ResultW, 128'hDEADBEEF);

    // 5: vector load wrapping past the top of the address space
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 6'd4, 32'h5000, 128'hFFFFFFF8, 128'h0, 0, stalls, bbad);
    check_val("t5_nbeats", 128'(log_addr.size()), 128'd4);
    exp_addr = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};
    for (int i = 0; i < 4 && i < log_addr.size(); i++)
      check_val($sformatf("t5_addr%0d", i), 128'(log_addr[i]), 128'(exp_addr[i]));
    check_val("t5_readdataw", ReadDataW, 128'h000000A1_000000A0_000000A3_000000A2);

    // 6: reset asserted while beat 2 of a vector load is outstanding
    log_addr.delete(); log_data.delete(); log_we.delete();
    lat = 1;
    RegWriteM = 1'b1; ResultSrcM = 1'b1; is_vectorialM = 1'b1; RD_M = 6'd7;
    PCPlus4M = 32'h6000; ALU_ResultM = 128'h500;
    for (int n = 0; n < 50 && log_addr.size() < 2; n++) @(negedge clk);
    check_val("t6_reached_beat2", 128'(log_addr.size()), 128'd2);
    @(posedge clk); #1;
    check_val("t6_beat2_req", 128'(mem_bus.mem_req), 128'd1);
    check_val("t6_beat2_addr", 128'(mem_bus.mem_addr), 128'h508);
    #2;
    rst = 1'b1;
    #1;
    check_val("t6_rst_req", 128'(mem_bus.mem_req), 128'd0);
    check_val("t6_rst_stall", 128'(StallM), 128'd0);
    check_val("t6_rst_aluw", ALU_ResultW, 128'd0);
    check_val("t6_rst_readw", ReadDataW, 128'd0);
    check_val("t6_rst_pcw", 128'(PCPlus4W), 128'd0);
    check_val("t6_rst_resultw", ResultW, 128'd0);
    set_nop();
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'h7000, 128'h400, 128'h55, 0, stalls, bbad);
    check_val("t6_post_stalls", 128'(stalls), 128'd0);
    check_val("t6_post_nbeats", 128'(log_addr.size()), 128'd1);
    if (log_addr.size() > 0) begin
      check_val("t6_post_addr", 128'(log_addr[0]), 128'h400);
      check_val("t6_post_data", 128'(log_data[0]), 128'h55);
      check_val("t6_post_we", 128'(log_we[0]), 128'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_cycle_vec.md
Name: memory_cycle_vec

Overview:
Memory pipeline stage. It sits directly downstream of the execute stage and consumes its M-side pipeline outputs. It serialises 128-bit vector loads and stores onto a 32-bit data-memory port using a req/ack handshake, and stalls upstream stages while a transfer is in flight. It registers the results into the W stage and produces ResultW for writeback and for forwarding back into execute.

Parameters:
ADDR_W, 32, byte-address width of the data-memory port
BEAT_W, 32, data-memory port width in bits
VEC_W, 128, vector register width
BEATS, 4, beats per vector access (VEC_W/BEAT_W)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
RegWriteM  in  1  instruction in M writes the register file
MemWriteM  in  1  store
ResultSrcM  in  1  load (1 = result comes from memory)
is_vectorialM  in  1  1 = 128-bit access (4 beats), 0 = scalar (1 beat)
RD_M  in  6  destination register
PCPlus4M  in  32  PC+4 of the instruction
ALU_ResultM  in  128  bits [31:0] hold the byte address for memory ops; otherwise the result
WriteDataM  in  128  store data
mem_req  out  1  beat request; held until acked
mem_we  out  1  1 = write beat
mem_addr  out  ADDR_W  beat address
mem_wdata  out  BEAT_W  beat write data
mem_rdata  in  BEAT_W  beat read data, valid when mem_ack=1
mem_ack  in  1  beat completes this cycle
StallM  out  1  upstream must hold its M-side registers and the PC
RegWriteW  out  1  registered
ResultSrcW  out  1  registered
RD_W  out  6  registered
PCPlus4W  out  32  registered
ALU_ResultW  out  128  registered
ReadDataW  out  128  registered
ResultW  out  128  ResultSrcW ? ReadDataW : ALU_ResultW (combinational)

Behaviour:
- memop = MemWriteM | ResultSrcM.
  - MemWriteM and ResultSrcM both 1 is treated as a store; RegWriteW is forced to 0 for it.
- nbeats = is_vectorialM ? BEATS : 1.
- Address per beat: base = ALU_ResultM[31:0] with bits [1:0] forced to 0; beat i goes to base + 4*i. The address wraps modulo 2^32 with no error.
- mem_wdata = WriteDataM[32i+31:32i]; mem_we = MemWriteM.
- FSM states and transitions:
  - IDLE, beat counter = 0:
    - memop=1: mem_req=1 for beat 0.
    - Ack on the last beat: complete.
    - Ack on a non-final beat: go to BURST with counter=1.
    - No ack: stay in IDLE with the request held.
  - BURST: mem_req=1 for beat counter.
    - Each ack increments the counter.
    - Ack when counter = nbeats-1: complete and return to IDLE with counter=0.
- Load data capture: each acked beat writes mem_rdata into load buffer slice [32i+31:32i]. On a scalar load, ReadDataW[127:32] = 0.
- StallM = memop & ~(mem_ack & counter == nbeats-1). It is combinational, so a single-beat op acked in the same cycle causes no stall.
- W register update at every posedge:
  - StallM=0: capture all M fields; ReadDataW = assembled buffer, with the final beat taken directly from mem_rdata.
  - StallM=1: insert a bubble (RegWriteW=0, ResultSrcW=0). The other W fields hold their previous values.
- Latency:
  - Non-memory op: 1 cycle, M to W.
  - Memory op: (number of cycles until the final ack) + 1.
  - Best case is 1 cycle scalar and 4 cycles vector (ack on every cycle).
- M inputs are required to stay stable while StallM=1. The block does not re-latch them.
- mem_req may only fall after an ack or under reset.
- Reset (async, active-high), including mid-burst:
  - The burst is aborted, FSM to IDLE, counter=0, load buffer cleared.
  - mem_req=0 immediately.
  - All W outputs are 0, so ResultW=0.
  - StallM is 0 during reset.

Decomposition:
- Shared package mem_pkg holds:
  - BEAT_W, VEC_W, BEATS
  - the FSM state enum (IDLE, BURST)
  - beat-address helper constant BEAT_BYTES=4
- One natural sub-module, beat_serializer: holds the FSM, beat counter, req/addr/wdata generation and load-buffer assembly.
- The top level holds the W pipeline register and the ResultW mux.

Test Plan:
1. Non-memory op: RegWriteM=1, RD_M=5, ALU_ResultM=0x...0042 → next cycle RegWriteW=1, RD_W=5, ResultW=0x42, StallM=0 throughout.
2. Vector store with mem_ack tied to 1: addr=0x100, WriteDataM=0x44444444_33333333_22222222_11111111 → beats to 0x100/104/108/10C carry 11111111, 22222222, 33333333, 44444444; StallM high for 3 cycles; RegWriteW=0 on completion.
3. Vector load where ack arrives 2 cycles after each req, mem_rdata = beat index+0xA0 → ReadDataW=0x...A3_...A2_...A1_...A0; StallM high for 11 cycles; bubbles in W meanwhile; ResultW=ReadDataW after capture.
4. Scalar load, addr=0x203 (misaligned), immediate ack, rdata=0xDEADBEEF → mem_addr=0x200; no stall; ReadDataW=0x0…0DEADBEEF.
5. Address wrap: vector load at 0xFFFFFFF8 → beat addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
6. Assert rst during BURST beat 2 → mem_req=0 and all W outputs 0 asynchronously; after release, a new scalar store starts at beat 0 correctly.
